power_domain_sequencer: RTL and testbench
=========================================

# power_domain_sequencer

Multi-channel power-gating sequencer that drives isolation, retention save/restore and power-switch enables for `NUM_DOMAINS` independently gated logic blocks. A single power-up token, arbitrated round-robin, limits inrush current: at most one domain ramps its rail at a time. Power-down waits for a retention acknowledge and is bounded by a timeout that raises a sticky error. The block sits between the system power manager (per-domain requests and acks) and the domain power switches and isolation cells.

## Interface
- `NUM_DOMAINS`, 4: number of gated domains, 1..16.
- `CNT_W`, 8: width of the stabilisation and timeout counters.
- `STABLE_CYCLES`, 10: cycles of rail settling after switch-on, 1..2^CNT_W-1.
- `ACK_TIMEOUT`, 200: maximum cycles spent in DN_SAVE; 0 disables the timeout (wait forever). Range 0..2^CNT_W-1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `power_on_req`  in  NUM_DOMAINS  per-domain level request to power up.
- `power_off_req`  in  NUM_DOMAINS  per-domain level request to power down.
- `ack_from_block`  in  NUM_DOMAINS  per-domain acknowledge that state save is complete.
- `err_clr`  in  1  pulse; clears all `err_timeout` bits.
- `isolate_en`  out  NUM_DOMAINS  isolation enable (1 = outputs clamped).
- `save_state`  out  NUM_DOMAINS  retention save command.
- `restore_state`  out  NUM_DOMAINS  retention restore command.
- `power_switch_en`  out  NUM_DOMAINS  power switch enable (1 = rail on).
- `power_on_ack`  out  NUM_DOMAINS  domain is on and de-isolated.
- `power_off_ack`  out  NUM_DOMAINS  single-cycle pulse marking shutdown complete.
- `err_timeout`  out  NUM_DOMAINS  sticky flag: save ack timed out.
- `up_busy`  out  1  the power-up token is held.

## Operation
- Each domain has its own FSM and counter. All outputs are decoded from registered state only; no input reaches an output combinationally.
- States and outputs (iso/save/rest/sw/onack/offack):
  - OFF: 1/0/0/0/0/0.
  - PEND: 1/0/0/0/0/0.
  - STABLE: 1/0/0/1/0/0.
  - RESTORE: 1/0/1/1/0/0.
  - ON: 0/0/0/1/1/0.
  - DN_ISO: 1/0/0/1/0/0.
  - DN_SAVE: 1/1/0/1/0/0.
  - DN_CUT: 1/0/0/0/0/1.
- State transitions:
  - OFF -> PEND when `power_on_req[i]`; `power_off_req` is ignored in OFF.
  - PEND -> STABLE when the domain wins the token. The counter loads STABLE_CYCLES at that edge.
  - PEND -> OFF when `power_off_req[i]` (cancel). Cancel takes precedence over a same-cycle grant; the token is then not consumed.
  - STABLE: the counter decrements each cycle; -> RESTORE when counter == 1. Total time in STABLE is exactly STABLE_CYCLES cycles.
  - RESTORE -> ON after exactly 1 cycle. The token is released at this edge.
  - ON -> DN_ISO when `power_off_req[i]`. If both requests are high, power-down wins; `power_on_req` is ignored in ON.
  - DN_ISO -> DN_SAVE after 1 cycle. The counter loads 0.
  - DN_SAVE -> DN_CUT when `ack_from_block[i]`.
  - DN_SAVE -> DN_CUT also when ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT-1 without an ack. This sets `err_timeout[i]`.
  - DN_CUT -> OFF after 1 cycle.
- Requests are level-sensitive and never queued. A request seen in a state that does not consume it has no effect.
- Token arbiter:
  - Grants when the token is free and at least one domain is in PEND.
  - Search starts at (last_grant+1) mod NUM_DOMAINS and wraps. last_grant resets to NUM_DOMAINS-1, so domain 0 has first priority after reset.
  - At most one grant per cycle. Power-down sequences never need the token.
- `err_timeout[i]` is set on timeout and held until `err_clr`. If set and clear coincide, set wins.
- Reset (asynchronous, any time, including mid-sequence):
  - All FSMs go to OFF, counters to 0, token free, last_grant to NUM_DOMAINS-1, `err_timeout` to 0.
  - Outputs at reset: `isolate_en` all 1s. `save_state`, `restore_state`, `power_switch_en`, `power_on_ack`, `power_off_ack` and `up_busy` all 0.

## Timing
- Power-up latency, token free, request first sampled at edge E: PEND at E, STABLE at E+1, RESTORE at E+1+STABLE_CYCLES, ON at E+2+STABLE_CYCLES.
- `power_on_ack` rises at E+2+STABLE_CYCLES.
- `up_busy` is high from E+1 through the cycle spent in RESTORE.
- A domain in PEND behind a busy token is granted at the edge where the holder leaves RESTORE. It enters STABLE one edge later; token idle time between holders is 1 cycle.
- Power-down with the ack already high, off_req sampled at edge F: DN_ISO at F, DN_SAVE at F+1, DN_CUT at F+2, OFF at F+3.
- `power_off_ack` is high for the single cycle between F+2 and F+3.
- Timeout: DN_SAVE lasts exactly ACK_TIMEOUT cycles. `err_timeout` rises on the same edge as entry to DN_CUT.

## Test plan
- Reset mid-STABLE on domain 1: assert `rst` asynchronously -> all outputs immediately go to reset values, `up_busy`=0, and domain 1 re-sequences from OFF after reset is released.
- Single domain 0, STABLE_CYCLES=10: `power_on_req[0]` held from cycle 0 -> `power_switch_en[0]` rises at cycle 1, `restore_state[0]` pulses at cycle 11, `power_on_ack[0]` and `isolate_en[0]`=0 from cycle 12.
- All 4 domains request together -> grants in order 0,1,2,3, each STABLE+RESTORE+1 = 12 cycles apart; `power_switch_en` never has two domains rising inside one STABLE window.
- Power-down of domain 2 with ack arriving 5 cycles into DN_SAVE -> `save_state[2]` high 6 cycles, `power_off_ack[2]` pulses once, `err_timeout[2]`=0.
- ACK_TIMEOUT=20, ack never asserted -> DN_SAVE lasts 20 cycles, `err_timeout[3]`=1 and sticky; `err_clr` -> 0; a same-cycle set and clear -> 1.
- `power_off_req[1]` raised while domain 1 is in PEND behind a busy token -> domain 1 returns to OFF, is never granted, and the round-robin pointer is unchanged.

Source files
------------

// File: rtl/power_domain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : power_domain_sequencer
//  Description : Per-domain power-gating sequencer. It drives isolation,
//                retention save/restore and power-switch enables. A single
//                round-robin power-up token limits inrush to one ramping rail
//                at a time. Power-down waits for a retention ack, bounded by
//                an optional timeout that sets a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_domain_sequencer #(
   parameter int NUM_DOMAINS   = 4,
   parameter int CNT_W         = 8,
   parameter int STABLE_CYCLES = 10,
   parameter int ACK_TIMEOUT   = 200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_DOMAINS-1:0] power_on_req,
   input  logic [NUM_DOMAINS-1:0] power_off_req,
   input  logic [NUM_DOMAINS-1:0] ack_from_block,
   input  logic                   err_clr,
   output logic [NUM_DOMAINS-1:0] isolate_en,
   output logic [NUM_DOMAINS-1:0] save_state,
   output logic [NUM_DOMAINS-1:0] restore_state,
   output logic [NUM_DOMAINS-1:0] power_switch_en,
   output logic [NUM_DOMAINS-1:0] power_on_ack,
   output logic [NUM_DOMAINS-1:0] power_off_ack,
   output logic [NUM_DOMAINS-1:0] err_timeout,
   output logic                   up_busy
);

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] C_STABLE_LOAD  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam bit               C_TIMEOUT_EN   = (ACK_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);

   // Output word per state: {iso, save, restore, switch, on_ack, off_ack}
   localparam logic [5:0] C_OUT_OFF     = 6'b100000;
   localparam logic [5:0] C_OUT_PEND    = 6'b100000;
   localparam logic [5:0] C_OUT_STABLE  = 6'b100100;
   localparam logic [5:0] C_OUT_RESTORE = 6'b101100;
   localparam logic [5:0] C_OUT_ON      = 6'b000110;
   localparam logic [5:0] C_OUT_DN_ISO  = 6'b100100;
   localparam logic [5:0] C_OUT_DN_SAVE = 6'b110100;
   localparam logic [5:0] C_OUT_DN_CUT  = 6'b100001;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_PEND    = 3'd1,
      ST_STABLE  = 3'd2,
      ST_RESTORE = 3'd3,
      ST_ON      = 3'd4,
      ST_DN_ISO  = 3'd5,
      ST_DN_SAVE = 3'd6,
      ST_DN_CUT  = 3'd7
   } state_t;

   // Token arbiter state
   logic             busy_q;
   logic             busy_d;
   logic [IDX_W-1:0] last_grant_q;
   logic [IDX_W-1:0] last_grant_d;

   // Arbiter combinational signals
   logic [NUM_DOMAINS-1:0] w_elig;
   logic [NUM_DOMAINS-1:0] w_in_restore;
   logic [NUM_DOMAINS-1:0] w_grant;
   logic                   w_grant_vld;
   logic [IDX_W-1:0]       w_grant_idx;
   logic [IDX_W:0]         w_probe;
   logic [IDX_W-1:0]       w_probe_idx;

   // Round-robin search for the first eligible PEND domain after last_grant
   always_comb begin
      w_grant     = '0;
      w_grant_vld = 1'b0;
      w_grant_idx = last_grant_q;
      w_probe     = '0;
      w_probe_idx = '0;
      if (!busy_q) begin
         for (int k = 0; k < NUM_DOMAINS; k++) begin
            w_probe = {1'b0, last_grant_q} + (IDX_W+1)'(k + 1);
            if (w_probe >= (IDX_W+1)'(NUM_DOMAINS)) begin
               w_probe = w_probe - (IDX_W+1)'(NUM_DOMAINS);
            end
            w_probe_idx = w_probe[IDX_W-1:0];
            if (!w_grant_vld && w_elig[w_probe_idx]) begin
               w_grant_vld = 1'b1;
               w_grant_idx = w_probe_idx;
            end
         end
      end
      if (w_grant_vld) begin
         w_grant[w_grant_idx] = 1'b1;
      end
   end

   // Token next state: taken on grant, returned when the holder leaves RESTORE
   always_comb begin
      busy_d       = busy_q;
      last_grant_d = last_grant_q;
      if (w_grant_vld) begin
         busy_d       = 1'b1;
         last_grant_d = w_grant_idx;
      end else if (|w_in_restore) begin
         busy_d = 1'b0;
      end
   end

   // Token and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q       <= 1'b0;
         last_grant_q <= IDX_W'(NUM_DOMAINS - 1);
      end else begin
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign up_busy = busy_q;

   for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic [5:0]       out_q;
      logic             err_q;

      // A cancel in the same cycle keeps the domain out of arbitration
      assign w_elig[gi]       = (state_q == ST_PEND) && !power_off_req[gi];
      assign w_in_restore[gi] = (state_q == ST_RESTORE);

      assign {isolate_en[gi], save_state[gi], restore_state[gi],
              power_switch_en[gi], power_on_ack[gi], power_off_ack[gi]} = out_q;
      assign err_timeout[gi] = err_q;

      // Domain sequencer: state, counter, registered output word, sticky error
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            out_q   <= C_OUT_OFF;
            err_q   <= 1'b0;
         end else begin
            // A timeout set later in this block overrides a same-cycle clear
            if (err_clr) begin
               err_q <= 1'b0;
            end
            case (state_q)
               ST_OFF: begin
                  if (power_on_req[gi]) begin
                     state_q <= ST_PEND;
                     out_q   <= C_OUT_PEND;
                  end
               end
               ST_PEND: begin
                  if (power_off_req[gi]) begin
                     state_q <= ST_OFF;
                     out_q   <= C_OUT_OFF;
                  end else if (w_grant[gi]) begin
                     state_q <= ST_STABLE;
                     cnt_q   <= C_STABLE_LOAD;
                     out_q   <= C_OUT_STABLE;
                  end
               end
               ST_STABLE: begin
                  cnt_q <= cnt_q - C_CNT_ONE;
                  if (cnt_q == C_CNT_ONE) begin
                     state_q <= ST_RESTORE;
                     out_q   <= C_OUT_RESTORE;
                  end
               end
               ST_RESTORE: begin
                  state_q <= ST_ON;
                  out_q   <= C_OUT_ON;
               end
               ST_ON: begin
                  if (power_off_req[gi]) begin
                     state_q <= ST_DN_ISO;
                     out_q   <= C_OUT_DN_ISO;
                  end
               end
               ST_DN_ISO: begin
                  state_q <= ST_DN_SAVE;
                  cnt_q   <= '0;
                  out_q   <= C_OUT_DN_SAVE;
               end
               ST_DN_SAVE: begin
                  if (ack_from_block[gi]) begin
                     state_q <= ST_DN_CUT;
                     out_q   <= C_OUT_DN_CUT;
                  end else if (C_TIMEOUT_EN && (cnt_q == C_TIMEOUT_LAST)) begin
                     state_q <= ST_DN_CUT;
                     out_q   <= C_OUT_DN_CUT;
                     err_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + C_CNT_ONE;
                  end
               end
               ST_DN_CUT: begin
                  state_q <= ST_OFF;
                  out_q   <= C_OUT_OFF;
               end
               default: begin
                  state_q <= ST_OFF;
                  out_q   <= C_OUT_OFF;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_power_domain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_domain_sequencer
//  Description : Directed bench for power_domain_sequencer with a per-cycle
//                behavioural model (phase + elapsed time + token holder) and
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_domain_sequencer;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int SC = 10;
   localparam int TO = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] on_req, off_req, ack;
   logic         err_clr;
   logic [N-1:0] iso, sv, rs, sw, onack, offack, errt;
   logic         busy;

   power_domain_sequencer #(
      .NUM_DOMAINS  (N),
      .CNT_W        (CW),
      .STABLE_CYCLES(SC),
      .ACK_TIMEOUT  (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .power_on_req   (on_req),
      .power_off_req  (off_req),
      .ack_from_block (ack),
      .err_clr        (err_clr),
      .isolate_en     (iso),
      .save_state     (sv),
      .restore_state  (rs),
      .power_switch_en(sw),
      .power_on_ack   (onack),
      .power_off_ack  (offack),
      .err_timeout    (errt),
      .up_busy        (busy)
   );

   always #5 clk = ~clk;

   // Model phases
   localparam int P_OFF = 0, P_WAIT = 1, P_RAMP = 2, P_REST = 3;
   localparam int P_ON  = 4, P_ISO  = 5, P_SAVE = 6, P_CUT  = 7;

   int ph[N];
   int tm[N];
   bit merr[N];
   int holder;
   int last;

   int n_vec = 0;
   int n_mis = 0;

   int rise[N];
   int nsave, noff, erise, orise, seen1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         ph[i]   = P_OFF;
         tm[i]   = 0;
         merr[i] = 1'b0;
      end
      holder = -1;
      last   = N - 1;
   endtask

   // One clock edge of the reference behaviour
   task automatic model_step();
      int g;
      bit tset;
      g = -1;
      if (rst) begin
         model_reset();
         return;
      end
      if (holder < 0) begin
         for (int k = 1; k <= N; k++) begin
            int d;
            d = (last + k) % N;
            if (g < 0 && ph[d] == P_WAIT && !off_req[d]) g = d;
         end
      end
      for (int i = 0; i < N; i++) begin
         tset = 1'b0;
         case (ph[i])
            P_OFF:  if (on_req[i]) ph[i] = P_WAIT;
            P_WAIT: begin
               if (off_req[i]) ph[i] = P_OFF;
               else if (g == i) begin ph[i] = P_RAMP; tm[i] = 0; end
            end
            P_RAMP: begin
               if (tm[i] == SC - 1) ph[i] = P_REST;
               else tm[i]++;
            end
            P_REST: begin ph[i] = P_ON; holder = -1; end
            P_ON:   if (off_req[i]) ph[i] = P_ISO;
            P_ISO:  begin ph[i] = P_SAVE; tm[i] = 0; end
            P_SAVE: begin
               if (ack[i]) ph[i] = P_CUT;
               else if (TO != 0 && tm[i] == TO - 1) begin ph[i] = P_CUT; tset = 1'b1; end
               else tm[i]++;
            end
            default: ph[i] = P_OFF;
         endcase
         if (tset) merr[i] = 1'b1;
         else if (err_clr) merr[i] = 1'b0;
      end
      if (g >= 0) begin
         holder = g;
         last   = g;
      end
   endtask

   // {iso, save, restore, switch, on_ack, off_ack} for each phase
   function automatic logic [5:0] tbl(input int p);
      case (p)
         P_RAMP:  return 6'b100100;
         P_REST:  return 6'b101100;
         P_ON:    return 6'b000110;
         P_ISO:   return 6'b100100;
         P_SAVE:  return 6'b110100;
         P_CUT:   return 6'b100001;
         default: return 6'b100000;
      endcase
   endfunction

   task automatic compare();
      logic [N-1:0] e_iso, e_sv, e_rs, e_sw, e_on, e_off, e_err;
      for (int i = 0; i < N; i++) begin
         {e_iso[i], e_sv[i], e_rs[i], e_sw[i], e_on[i], e_off[i]} = tbl(ph[i]);
         e_err[i] = merr[i];
      end
      chk("isolate_en", iso, e_iso);
      chk("save_state", sv, e_sv);
      chk("restore_state", rs, e_rs);
      chk("power_switch_en", sw, e_sw);
      chk("power_on_ack", onack, e_on);
      chk("power_off_ack", offack, e_off);
      chk("err_timeout", errt, e_err);
      chk("up_busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, (holder >= 0)});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   initial begin
      rst = 1'b1; on_req = '0; off_req = '0; ack = '0; err_clr = 1'b0;
      model_reset();
      cyc(); cyc();
      chk("rst_iso", iso, 4'hF);
      chk("rst_sw", sw | sv | rs | onack | offack | errt, 4'h0);
      chk("rst_busy", {3'b0, busy}, 4'h0);
      rst = 1'b0;

      // Asynchronous reset in the middle of domain 1's STABLE window
      on_req[1] = 1'b1;
      repeat (4) cyc();
      chk("pre_async_sw", sw, 4'b0010);
      chk("pre_async_busy", {3'b0, busy}, 4'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_iso", iso, 4'hF);
      chk("async_sw", sw | rs | onack, 4'h0);
      chk("async_busy", {3'b0, busy}, 4'h0);
      model_reset();
      cyc();
      rst = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         cyc();
         if (k == 0) chk("reseq_sw0", sw, 4'b0000);
         if (k == 1) chk("reseq_sw1", sw, 4'b0010);
      end
      chk("reseq_onack", onack, 4'b0010);
      on_req = '0;
      ack[1] = 1'b1; off_req[1] = 1'b1;
      cyc();
      off_req = '0;
      repeat (4) cyc();
      ack = '0;

      // Single domain 0 power-up timing
      on_req[0] = 1'b1;
      for (int k = 0; k <= 13; k++) begin
         cyc();
         chk_int("d0_sw", int'(sw[0]), (k >= 1) ? 1 : 0);
         chk_int("d0_restore", int'(rs[0]), (k == 11) ? 1 : 0);
         chk_int("d0_onack", int'(onack[0]), (k >= 12) ? 1 : 0);
         chk_int("d0_iso", int'(iso[0]), (k >= 12) ? 0 : 1);
      end
      on_req = '0;

      // Domain 0 power-down with the ack already high
      ack[0] = 1'b1; off_req[0] = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         cyc();
         off_req = '0;
         chk_int("d0_save", int'(sv[0]), (k == 1) ? 1 : 0);
         chk_int("d0_offack", int'(offack[0]), (k == 2) ? 1 : 0);
      end
      ack = '0;

      // All four request together right after reset: order 0,1,2,3
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      on_req = 4'hF;
      for (int i = 0; i < N; i++) rise[i] = -1;
      for (int k = 0; k <= 50; k++) begin
         logic [N-1:0] prev;
         prev = sw;
         cyc();
         for (int i = 0; i < N; i++) if (!prev[i] && sw[i] && rise[i] < 0) rise[i] = k;
      end
      chk_int("rise_d0", rise[0], 1);
      chk_int("rise_d1", rise[1], 13);
      chk_int("rise_d2", rise[2], 25);
      chk_int("rise_d3", rise[3], 37);
      on_req = '0;

      // Domain 2 power-down, ack sampled 6 cycles into DN_SAVE
      off_req[2] = 1'b1;
      cyc();
      off_req = '0;
      nsave = 0; noff = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 7) ack[2] = 1'b1;
         cyc();
         if (sv[2]) nsave++;
         if (offack[2]) noff++;
      end
      ack = '0;
      chk_int("d2_save_len", nsave, 6);
      chk_int("d2_offack_cnt", noff, 1);
      chk_int("d2_err", int'(errt[2]), 0);

      // Domain 3 timeout with no ack
      off_req[3] = 1'b1;
      cyc();
      off_req = '0;
      nsave = 0; erise = -1; orise = -1;
      for (int k = 1; k <= 24; k++) begin
         cyc();
         if (sv[3]) nsave++;
         if (errt[3] && erise < 0) erise = k;
         if (offack[3] && orise < 0) orise = k;
      end
      chk_int("d3_save_len", nsave, 20);
      chk_int("d3_err_edge", erise, 21);
      chk_int("d3_cut_edge", orise, 21);
      repeat (3) cyc();
      chk_int("d3_err_sticky", int'(errt[3]), 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk_int("d3_err_clr", int'(errt[3]), 0);

      // Second timeout with err_clr on the timeout edge: set wins
      on_req[3] = 1'b1;
      repeat (14) cyc();
      on_req = '0;
      chk_int("d3_reon", int'(onack[3]), 1);
      off_req[3] = 1'b1;
      cyc();
      off_req = '0;
      repeat (20) cyc();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk_int("d3_set_wins", int'(errt[3]), 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;

      // Cancel of domain 1 while waiting behind domain 0's token
      ack = 4'b0011; off_req = 4'b0011;
      cyc();
      off_req = '0;
      repeat (4) cyc();
      ack = '0;
      on_req = 4'b0011;
      cyc(); cyc();
      chk("cancel_grant0", sw, 4'b0001);
      repeat (2) cyc();
      on_req[1] = 1'b0; off_req[1] = 1'b1;
      cyc();
      off_req = '0;
      seen1 = 0;
      for (int k = 0; k < 14; k++) begin
         cyc();
         if (sw[1]) seen1++;
      end
      chk_int("cancel_no_grant", seen1, 0);
      chk_int("cancel_d0_on", int'(onack[0]), 1);
      on_req = 4'b0110;
      cyc(); cyc();
      chk("rr_after_cancel", sw & 4'b0110, 4'b0010);
      repeat (30) cyc();
      on_req = '0;
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
